// File: rtl/sonar_pkg.sv
// Shared types and 50 MHz timing defaults for the sonar scheduler.
// Optional build macro: SONAR_AUTO_REPEAT_EN (continuous sweeps).
package sonar_pkg;

    localparam int SENSOR_N = 3;
    localparam int DIST_W   = 12;
    localparam int IDX_W    = 2;

    localparam int TRIG_CYCLES_DEF  = 500;
    localparam int TICK_CYCLES_DEF  = 2941;
    localparam int MAX_CM_DEF       = 400;
    localparam int RISE_TIMEOUT_DEF = 1_500_000;
    localparam int GAP_CYCLES_DEF   = 3_000_000;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SELECT    = 4'd1,
        S_TRIGGER   = 4'd2,
        S_WAIT_RISE = 4'd3,
        S_MEASURE   = 4'd4,
        S_STORE     = 4'd5,
        S_GAP       = 4'd6,
        S_DONE      = 4'd7
    } state_e;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_RISE = 2'd1,
        M_MEAS = 2'd2
    } meter_e;

    // {found, index} of the lowest enabled sensor after cur
    function automatic logic [IDX_W:0] pick_next(
        input logic [SENSOR_N-1:0] mask,
        input logic [IDX_W-1:0]    cur,
        input logic                first
    );
        logic [IDX_W:0] r;
        r = '0;
        for (int i = SENSOR_N - 1; i >= 0; i--) begin
            if (mask[i] && (first || i > int'(cur))) begin
                r = {1'b1, IDX_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sonar_scheduler_echo_meter.sv
// Echo timing engine: synchronizer, edge detect, rise timeout
// and saturating centimetre counter with an arm/fin handshake.
module echo_meter
    import sonar_pkg::*;
#(
    parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter int MAX_CM       = MAX_CM_DEF,
    parameter int RISE_TIMEOUT = RISE_TIMEOUT_DEF
)(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              arm_i,
    input  logic              echo_i,
    output logic [DIST_W-1:0] result_o,
    output logic              timeout_o,
    output logic              fin_o,
    output logic              meas_o
);

    localparam int SW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int RW = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;

    meter_e            st_q;
    logic [1:0]        sync_q;
    logic              prev_q;
    logic [SW-1:0]     sub_q;
    logic [RW-1:0]     rise_cnt_q;
    logic [DIST_W-1:0] cm_q;
    logic [DIST_W-1:0] result_q;
    logic              to_q;
    logic              fin_q;
    logic              rise;
    logic              fall;

    assign rise      = sync_q[1] & ~prev_q;
    assign fall      = ~sync_q[1] & prev_q;
    assign result_o  = result_q;
    assign timeout_o = to_q;
    assign fin_o     = fin_q;
    assign meas_o    = (st_q == M_MEAS);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_q       <= M_IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            sub_q      <= '0;
            rise_cnt_q <= '0;
            cm_q       <= '0;
            result_q   <= '0;
            to_q       <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], echo_i};
            prev_q <= sync_q[1];
            fin_q  <= 1'b0;
            unique case (st_q)
                M_IDLE: begin
                    if (arm_i) begin
                        rise_cnt_q <= '0;
                        cm_q       <= '0;
                        sub_q      <= SW'(1);
                        st_q       <= rise ? M_MEAS : M_RISE;
                    end
                end
                M_RISE: begin
                    // the rise cycle itself counts as the first tick
                    if (rise) begin
                        cm_q  <= '0;
                        sub_q <= SW'(1);
                        st_q  <= M_MEAS;
                    end else if (rise_cnt_q == RW'(RISE_TIMEOUT - 1)) begin
                        result_q <= DIST_W'(MAX_CM);
                        to_q     <= 1'b1;
                        fin_q    <= 1'b1;
                        st_q     <= M_IDLE;
                    end else begin
                        rise_cnt_q <= rise_cnt_q + 1'b1;
                    end
                end
                M_MEAS: begin
                    if (fall) begin
                        result_q <= cm_q;
                        to_q     <= 1'b0;
                        fin_q    <= 1'b1;
                        st_q     <= M_IDLE;
                    end else if (sub_q == SW'(TICK_CYCLES - 1)) begin
                        sub_q <= '0;
                        if (cm_q == DIST_W'(MAX_CM - 1)) begin
                            result_q <= DIST_W'(MAX_CM);
                            to_q     <= 1'b1;
                            fin_q    <= 1'b1;
                            st_q     <= M_IDLE;
                        end else begin
                            cm_q <= cm_q + 1'b1;
                        end
                    end else begin
                        sub_q <= sub_q + 1'b1;
                    end
                end
                default: st_q <= M_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one echo_meter among three sensors.
// Define SONAR_AUTO_REPEAT_EN to repeat sweeps without a new start.
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int TRIG_CYCLES  = TRIG_CYCLES_DEF,
    parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter int MAX_CM       = MAX_CM_DEF,
    parameter int RISE_TIMEOUT = RISE_TIMEOUT_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [SENSOR_N-1:0]        enable_mask,
    input  logic [SENSOR_N-1:0]        echo,
    output logic [SENSOR_N-1:0]        trigger,
    output logic [SENSOR_N*DIST_W-1:0] distance,
    output logic [SENSOR_N-1:0]        valid,
    output logic [SENSOR_N-1:0]        timeout,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 db_estado
);

    localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e                     state_q;
    logic [SENSOR_N-1:0]        mask_q;
    logic [SENSOR_N-1:0]        trig_q;
    logic [SENSOR_N-1:0]        valid_q;
    logic [SENSOR_N-1:0]        to_q;
    logic [SENSOR_N*DIST_W-1:0] dist_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       first_q;
    logic [TW-1:0]              trig_cnt_q;
    logic [GW-1:0]              gap_cnt_q;
    logic                       arm_q;
    logic                       busy_q;
    logic                       done_q;

    logic [IDX_W:0]    nxt;
    logic              echo_sel;
    logic [DIST_W-1:0] m_res;
    logic              m_to;
    logic              m_fin;
    logic              m_meas;

    assign nxt       = pick_next(mask_q, idx_q, first_q);
    assign trigger   = trig_q;
    assign distance  = dist_q;
    assign valid     = valid_q;
    assign timeout   = to_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign db_estado = state_q;

    always_comb begin
        echo_sel = 1'b0;
        for (int i = 0; i < SENSOR_N; i++) begin
            if (IDX_W'(i) == idx_q) echo_sel = echo[i];
        end
    end

    echo_meter #(
        .TICK_CYCLES  (TICK_CYCLES),
        .MAX_CM       (MAX_CM),
        .RISE_TIMEOUT (RISE_TIMEOUT)
    ) u_meter (
        .clk_i     (clock),
        .rst_ni    (reset),
        .arm_i     (arm_q),
        .echo_i    (echo_sel),
        .result_o  (m_res),
        .timeout_o (m_to),
        .fin_o     (m_fin),
        .meas_o    (m_meas)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            trig_q     <= '0;
            valid_q    <= '0;
            to_q       <= '0;
            dist_q     <= '0;
            idx_q      <= '0;
            first_q    <= 1'b1;
            trig_cnt_q <= '0;
            gap_cnt_q  <= '0;
            arm_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_q <= '0;
            done_q  <= 1'b0;
            arm_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mask_q  <= enable_mask;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (nxt[IDX_W]) begin
                        idx_q      <= nxt[IDX_W-1:0];
                        first_q    <= 1'b0;
                        trig_q     <= SENSOR_N'(1) << nxt[IDX_W-1:0];
                        trig_cnt_q <= '0;
                        state_q    <= S_TRIGGER;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_TRIGGER: begin
                    if (trig_cnt_q == TW'(TRIG_CYCLES - 1)) begin
                        trig_q  <= '0;
                        arm_q   <= 1'b1;
                        state_q <= S_WAIT_RISE;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + 1'b1;
                    end
                end
                S_WAIT_RISE, S_MEASURE: begin
                    // result lands with valid so both show during STORE
                    if (m_fin) begin
                        for (int i = 0; i < SENSOR_N; i++) begin
                            if (IDX_W'(i) == idx_q) begin
                                dist_q[i*DIST_W +: DIST_W] <= m_res;
                                to_q[i]    <= m_to;
                                valid_q[i] <= 1'b1;
                            end
                        end
                        state_q <= S_STORE;
                    end else if (m_meas) begin
                        state_q <= S_MEASURE;
                    end
                end
                S_STORE: begin
                    gap_cnt_q <= '0;
                    state_q   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        state_q <= S_SELECT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
`ifdef SONAR_AUTO_REPEAT_EN
                    mask_q  <= enable_mask;
                    first_q <= 1'b1;
                    if (|enable_mask) begin
                        state_q <= S_SELECT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`else
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Bench for sonar_scheduler: sensor echo responder, valid scoreboard,
// table of sweeps plus busy-start, reset-abort and auto-repeat cases.
module tb_sonar_scheduler;

    localparam int ECHO_DLY = 5;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  enable_mask;
    logic [2:0]  echo;
    logic [2:0]  trigger;
    logic [35:0] distance;
    logic [2:0]  valid;
    logic [2:0]  timeout;
    logic        busy;
    logic        done;
    logic [3:0]  db_estado;

    typedef struct {
        logic [2:0]  mask;
        int          w0;
        int          w1;
        int          w2;
        logic [11:0] d0;
        logic [11:0] d1;
        logic [11:0] d2;
        logic [2:0]  to;
        int          lat;
    } vec_t;

    typedef struct {
        int          idx;
        logic [11:0] d;
        logic        t;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[6];
    int   checks;
    int   errors;
    int   echo_w[3];
    int   trig_pulses[3];
    int   trig_len[3];
    int   done_cnt;
    logic overlap;
    logic auto_mode;

    sonar_scheduler #(
        .TRIG_CYCLES  (4),
        .TICK_CYCLES  (10),
        .MAX_CM       (20),
        .RISE_TIMEOUT (50),
        .GAP_CYCLES   (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .enable_mask (enable_mask),
        .echo        (echo),
        .trigger     (trigger),
        .distance    (distance),
        .valid       (valid),
        .timeout     (timeout),
        .busy        (busy),
        .done        (done),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Sensor model: echo rises ECHO_DLY cycles after trigger falls
    initial begin
        int   ph[3];
        int   cnt[3];
        logic [2:0] tprev;
        echo  = '0;
        tprev = '0;
        for (int i = 0; i < 3; i++) begin
            ph[i]  = 0;
            cnt[i] = 0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                case (ph[i])
                    0: if (tprev[i] && !trigger[i] && echo_w[i] > 0) begin
                        ph[i]  = 1;
                        cnt[i] = ECHO_DLY;
                    end
                    1: begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            echo[i] = 1'b1;
                            cnt[i]  = echo_w[i];
                            ph[i]   = 2;
                        end
                    end
                    default: begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            echo[i] = 1'b0;
                            ph[i]   = 0;
                        end
                    end
                endcase
            end
            tprev = trigger;
        end
    end

    // Monitor: trigger widths/overlap, done count, valid scoreboard
    initial begin
        sb_t e;
        for (int i = 0; i < 3; i++) trig_len[i] = 0;
        forever begin
            @(negedge clock);
            if ($countones(trigger) > 1) overlap = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (trigger[i]) begin
                    trig_len[i]++;
                end else if (trig_len[i] > 0) begin
                    check("trig_width", trig_len[i], 4);
                    trig_pulses[i]++;
                    trig_len[i] = 0;
                end
            end
            if (done) done_cnt++;
            if (valid != 0 && !auto_mode) begin
                check("valid_onehot", $onehot(valid), 1);
                if (sbq.size() == 0) begin
                    check("valid_unexpected", valid, 0);
                end else begin
                    e = sbq.pop_front();
                    check("valid_idx", valid, 3'(1) << e.idx);
                    check("valid_dist", distance[e.idx*12 +: 12], e.d);
                    check("valid_to", timeout[e.idx], e.t);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) trig_pulses[i] = 0;
        overlap  = 1'b0;
        done_cnt = 0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        string p;
        p = $sformatf("row%0d_", n);
        echo_w[0] = v.w0;
        echo_w[1] = v.w1;
        echo_w[2] = v.w2;
        clear_stats();
        if (v.mask[0]) sbq.push_back('{0, v.d0, v.to[0]});
        if (v.mask[1]) sbq.push_back('{1, v.d1, v.to[1]});
        if (v.mask[2]) sbq.push_back('{2, v.d2, v.to[2]});
        enable_mask = v.mask;
        pulse_start();
        @(negedge clock);
        check({p, "busy_on"}, busy, 1);
        lat = 1;
        while (!done && lat < 3000) begin
            @(negedge clock);
            lat++;
        end
        check({p, "done_seen"}, done, 1);
        check({p, "busy_off"}, busy, 0);
        if (v.lat != 0) check({p, "done_lat"}, lat, v.lat);
        repeat (20) @(negedge clock);
        check({p, "done_once"}, done_cnt, 1);
        check({p, "distance"}, distance, {v.d2, v.d1, v.d0});
        check({p, "timeout"}, timeout, v.to);
        for (int i = 0; i < 3; i++) begin
            check({p, "trig_pulses"}, trig_pulses[i], v.mask[i]);
        end
        check({p, "no_overlap"}, overlap, 0);
        check({p, "sb_empty"}, sbq.size(), 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        start       = 1'b0;
        enable_mask = '0;
        reset       = 1'b0;
        auto_mode   = 1'b0;
        for (int i = 0; i < 3; i++) echo_w[i] = 0;
        clear_stats();

        vecs[0] = '{3'b111, 55, 120, 0, 12'd5, 12'd12, 12'd20, 3'b100, 0};
        vecs[1] = '{3'b101, 30, 77, 199, 12'd3, 12'd12, 12'd19, 3'b000, 0};
        vecs[2] = '{3'b001, 250, 0, 0, 12'd20, 12'd12, 12'd19, 3'b001, 0};
        vecs[3] = '{3'b010, 0, 9, 0, 12'd20, 12'd0, 12'd19, 3'b001, 0};
        vecs[4] = '{3'b110, 0, 200, 10, 12'd20, 12'd20, 12'd1, 3'b011, 0};
        vecs[5] = '{3'b000, 0, 0, 0, 12'd20, 12'd20, 12'd1, 3'b011, 3};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_outputs", {trigger, valid, timeout, busy, done}, 0);
        check("rst_distance", distance, 0);
        check("rst_state", db_estado, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);

`ifdef SONAR_AUTO_REPEAT_EN
        begin
            int c;
            auto_mode = 1'b1;
            echo_w[0] = 30;
            echo_w[1] = 40;
            clear_stats();
            enable_mask = 3'b011;
            pulse_start();
            c = 0;
            while (done_cnt < 3 && c < 5000) begin
                @(negedge clock);
                c++;
                if (done) check("auto_busy_held", busy, 1);
            end
            check("auto_done_count", done_cnt >= 3, 1);
            check("auto_distance", distance[23:0], {12'd4, 12'd3});
            enable_mask = 3'b000;
            done_cnt = 0;
            c = 0;
            while (done_cnt == 0 && c < 3000) begin
                @(negedge clock);
                c++;
            end
            check("auto_last_done", done_cnt, 1);
            repeat (3) @(negedge clock);
            check("auto_idle_state", db_estado, 0);
            check("auto_idle_busy", busy, 0);
            repeat (300) @(negedge clock);
            check("auto_stopped", done_cnt, 1);
        end
`else
        for (int n = 0; n < 6; n++) run_vec(vecs[n], n);

        begin
            echo_w[0] = 40;
            echo_w[1] = 60;
            echo_w[2] = 0;
            clear_stats();
            sbq.push_back('{0, 12'd4, 1'b0});
            sbq.push_back('{1, 12'd6, 1'b0});
            enable_mask = 3'b011;
            pulse_start();
            repeat (30) @(negedge clock);
            enable_mask = 3'b111;
            pulse_start();
            enable_mask = 3'b000;
            repeat (600) @(negedge clock);
            check("busy_start_done_once", done_cnt, 1);
            check("busy_start_no_trig2", trig_pulses[2], 0);
            check("busy_start_sb_empty", sbq.size(), 0);
            check("busy_start_dist", distance[23:0], {12'd6, 12'd4});
            check("busy_start_idle", busy, 0);
        end

        begin
            int c;
            echo_w[0] = 150;
            clear_stats();
            sbq.push_back('{0, 12'd15, 1'b0});
            enable_mask = 3'b001;
            pulse_start();
            c = 0;
            while (db_estado != 4 && c < 500) begin
                @(negedge clock);
                c++;
            end
            check("abort_reached_measure", db_estado, 4);
            repeat (3) @(negedge clock);
            @(posedge clock);
            #1 reset = 1'b0;
            @(posedge clock);
            @(negedge clock);
            check("abort_outputs", {trigger, valid, timeout, busy, done}, 0);
            check("abort_distance", distance, 0);
            check("abort_state", db_estado, 0);
            @(posedge clock);
            @(posedge clock);
            #1 reset = 1'b1;
            sbq.delete();
            done_cnt = 0;
            repeat (400) @(negedge clock);
            check("abort_no_done", done_cnt, 0);
            check("abort_still_idle", db_estado, 0);
            check("abort_no_busy", busy, 0);
            check("abort_distance_kept", distance, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
